arcade_input_decoder: RTL and testbench

- Sits directly upstream of the galaxian core in the ZigZag top level.
- Turns PS/2 key events and merged joystick words into the registered per-player control lines the core consumes.
- Applies the Vert/Horz orientation remap to both players.
- Converts coin and start requests into fixed-width, rate-limited coin pulses so the game CPU always sees a clean coin input.

---
 rtl/arcade_input_decoder.sv | 254 +++++++++++++++++++++++++
 tb/tb_arcade_input_decoder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_decoder.sv
// Arcade control front end: PS/2 keys and joystick to registered player
// controls, with orientation remap and rate-limited coin pulses.
module arcade_input_decoder #(
    parameter int unsigned COIN_CYCLES        = 200000,
    parameter int unsigned GAP_CYCLES         = 200000,
    parameter int unsigned START_INSERTS_COIN = 1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy,
    input  logic        rotate,
    input  logic        clear,
    output logic [3:0]  p1_dir,
    output logic        p1_fire,
    output logic [3:0]  p2_dir,
    output logic        p2_fire,
    output logic        start1,
    output logic        start2,
    output logic        coin1,
    output logic        coin2,
    output logic        test
);

    localparam int unsigned MAX_CYC = (COIN_CYCLES > GAP_CYCLES) ? COIN_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);
    localparam logic [CNT_W-1:0] COIN_LOAD = CNT_W'(COIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

    // Key state slots
    localparam int unsigned K_UP1    = 0;
    localparam int unsigned K_DOWN1  = 1;
    localparam int unsigned K_LEFT1  = 2;
    localparam int unsigned K_RIGHT1 = 3;
    localparam int unsigned K_SPACE  = 4;
    localparam int unsigned K_CTRL   = 5;
    localparam int unsigned K_F1     = 6;
    localparam int unsigned K_F2     = 7;
    localparam int unsigned K_1      = 8;
    localparam int unsigned K_2      = 9;
    localparam int unsigned K_5      = 10;
    localparam int unsigned K_6      = 11;
    localparam int unsigned K_UP2    = 12;
    localparam int unsigned K_DOWN2  = 13;
    localparam int unsigned K_LEFT2  = 14;
    localparam int unsigned K_RIGHT2 = 15;
    localparam int unsigned K_FIRE2  = 16;
    localparam int unsigned K_TEST   = 17;
    localparam int unsigned NKEYS    = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } coin_state_e;

    logic              tog_q, tog_d;
    logic              init_q, init_d;
    logic [NKEYS-1:0]  key_q, key_d;
    logic              event_c;
    logic              pressed_c;

    logic [3:0]        p1_dir_q, p1_dir_d;
    logic [3:0]        p2_dir_q, p2_dir_d;
    logic              p1_fire_q, p1_fire_d;
    logic              p2_fire_q, p2_fire_d;
    logic              start1_q, start1_d;
    logic              start2_q, start2_d;
    logic              test_q, test_d;

    logic [3:0]        p1_raw_c, p2_raw_c;
    logic              start1_c, start2_c;
    logic [1:0]        trig_c;

    coin_state_e       state_q [2];
    coin_state_e       state_d [2];
    logic [CNT_W-1:0]  cnt_q   [2];
    logic [CNT_W-1:0]  cnt_d   [2];
    logic [1:0]        trig_prev_q, trig_prev_d;
    logic [1:0]        coin_q, coin_d;

    logic              unused_c;
    assign unused_c = ^joy[15:7];

    // Horizontal cabinets see the screen turned a quarter: remap directions
    function automatic logic [3:0] remap(input logic [3:0] d, input logic r);
        return r ? {d[1], d[0], d[2], d[3]} : d;
    endfunction

    // Toggle edge detect and key-state decode
    always_comb begin
        tog_d     = ps2_key[10];
        init_d    = 1'b0;
        key_d     = key_q;
        pressed_c = ps2_key[9];
        event_c   = (tog_q != ps2_key[10]) && !init_q;
        if (clear) begin
            key_d = '0;
        end else if (event_c) begin
            case (ps2_key[7:0])
                8'h75: key_d[K_UP1]    = pressed_c;
                8'h72: key_d[K_DOWN1]  = pressed_c;
                8'h6B: key_d[K_LEFT1]  = pressed_c;
                8'h74: key_d[K_RIGHT1] = pressed_c;
                default: begin
                    if (!ps2_key[8]) begin
                        case (ps2_key[7:0])
                            8'h29: key_d[K_SPACE]  = pressed_c;
                            8'h14: key_d[K_CTRL]   = pressed_c;
                            8'h05: key_d[K_F1]     = pressed_c;
                            8'h06: key_d[K_F2]     = pressed_c;
                            8'h16: key_d[K_1]      = pressed_c;
                            8'h1E: key_d[K_2]      = pressed_c;
                            8'h2E: key_d[K_5]      = pressed_c;
                            8'h36: key_d[K_6]      = pressed_c;
                            8'h2D: key_d[K_UP2]    = pressed_c;
                            8'h2B: key_d[K_DOWN2]  = pressed_c;
                            8'h23: key_d[K_LEFT2]  = pressed_c;
                            8'h34: key_d[K_RIGHT2] = pressed_c;
                            8'h1C: key_d[K_FIRE2]  = pressed_c;
                            8'h2C: key_d[K_TEST]   = pressed_c;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    // Merge keyboard and joystick requests into the next output values
    always_comb begin
        p1_raw_c = {key_q[K_UP1], key_q[K_DOWN1], key_q[K_LEFT1], key_q[K_RIGHT1]} | joy[3:0];
        p2_raw_c = {key_q[K_UP2], key_q[K_DOWN2], key_q[K_LEFT2], key_q[K_RIGHT2]} | joy[3:0];
        start1_c = key_q[K_F1] | key_q[K_1] | joy[5];
        start2_c = key_q[K_F2] | key_q[K_2] | joy[6];
        trig_c[0] = key_q[K_5] | ((START_INSERTS_COIN != 0) & (start1_c | start2_c));
        trig_c[1] = key_q[K_6];

        p1_dir_d  = remap(p1_raw_c, rotate);
        p2_dir_d  = remap(p2_raw_c, rotate);
        p1_fire_d = key_q[K_SPACE] | key_q[K_CTRL] | joy[4];
        p2_fire_d = key_q[K_FIRE2] | joy[4];
        start1_d  = start1_c;
        start2_d  = start2_c;
        test_d    = key_q[K_TEST];
        if (clear) begin
            p1_dir_d  = '0;
            p2_dir_d  = '0;
            p1_fire_d = 1'b0;
            p2_fire_d = 1'b0;
            start1_d  = 1'b0;
            start2_d  = 1'b0;
            test_d    = 1'b0;
        end
    end

    // Coin pulse FSMs: rising edge -> fixed pulse -> dead time, edges dropped while busy
    always_comb begin
        trig_prev_d = trig_c;
        coin_d      = '0;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (clear) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (trig_c[i] && !trig_prev_q[i]) begin
                            state_d[i] = ST_PULSE;
                            cnt_d[i]   = COIN_LOAD;
                        end
                    end
                    ST_PULSE: begin
                        if (cnt_q[i] == '0) begin
                            if (GAP_CYCLES == 0) begin
                                state_d[i] = ST_IDLE;
                                cnt_d[i]   = '0;
                            end else begin
                                state_d[i] = ST_GAP;
                                cnt_d[i]   = GAP_LOAD;
                            end
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (cnt_q[i] == '0) begin
                            state_d[i] = ST_IDLE;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            coin_d[i] = (state_d[i] == ST_PULSE);
        end
    end

    // State and output registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q       <= 1'b0;
            init_q      <= 1'b1;
            key_q       <= '0;
            p1_dir_q    <= '0;
            p2_dir_q    <= '0;
            p1_fire_q   <= 1'b0;
            p2_fire_q   <= 1'b0;
            start1_q    <= 1'b0;
            start2_q    <= 1'b0;
            test_q      <= 1'b0;
            trig_prev_q <= '0;
            coin_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            tog_q       <= tog_d;
            init_q      <= init_d;
            key_q       <= key_d;
            p1_dir_q    <= p1_dir_d;
            p2_dir_q    <= p2_dir_d;
            p1_fire_q   <= p1_fire_d;
            p2_fire_q   <= p2_fire_d;
            start1_q    <= start1_d;
            start2_q    <= start2_d;
            test_q      <= test_d;
            trig_prev_q <= trig_prev_d;
            coin_q      <= coin_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign p1_dir  = p1_dir_q;
    assign p2_dir  = p2_dir_q;
    assign p1_fire = p1_fire_q;
    assign p2_fire = p2_fire_q;
    assign start1  = start1_q;
    assign start2  = start2_q;
    assign coin1   = coin_q[0];
    assign coin2   = coin_q[1];
    assign test    = test_q;

endmodule

// File: tb/tb_arcade_input_decoder.sv
// Bench for arcade_input_decoder: vector table plus coin/clear/reset sequences.
module tb_arcade_input_decoder;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [15:0] joy;
    logic        rotate;
    logic        clear;
    logic [3:0]  p1_dir, p2_dir;
    logic        p1_fire, p2_fire, start1, start2, coin1, coin2, test;

    always #5 clk_sys = ~clk_sys;

    arcade_input_decoder #(
        .COIN_CYCLES(4),
        .GAP_CYCLES(3),
        .START_INSERTS_COIN(1)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .ps2_key(ps2_key),
        .joy(joy),
        .rotate(rotate),
        .clear(clear),
        .p1_dir(p1_dir),
        .p1_fire(p1_fire),
        .p2_dir(p2_dir),
        .p2_fire(p2_fire),
        .start1(start1),
        .start2(start2),
        .coin1(coin1),
        .coin2(coin2),
        .test(test)
    );

    logic [14:0] got;
    assign got = {p1_dir, p1_fire, p2_dir, p2_fire, start1, start2, coin1, coin2, test};

    typedef struct {
        logic [10:0] ps2;
        logic [15:0] joy;
        logic        rot;
        logic        clr;
        logic [14:0] exp;
    } vec_t;

    typedef struct {
        logic [14:0] exp;
        string       name;
    } sb_t;

    vec_t        vecs[$];
    sb_t         sbq[$];
    int          checks   = 0;
    int          failures = 0;
    logic        tog;
    logic [10:0] cur_ps2;

    localparam logic [3:0] UP = 4'b1000, DN = 4'b0100, LT = 4'b0010, RT = 4'b0001, NO = 4'b0000;

    function automatic logic [10:0] mk(input logic t, input logic p, input logic e, input logic [7:0] c);
        return {t, p, e, c};
    endfunction

    function automatic logic [14:0] o(input logic [3:0] p1d, input logic p1f, input logic [3:0] p2d,
                                      input logic p2f, input logic s1, input logic s2,
                                      input logic c1, input logic c2, input logic t);
        return {p1d, p1f, p2d, p2f, s1, s2, c1, c2, t};
    endfunction

    function automatic logic [14:0] oc(input logic c1, input logic c2);
        return o(NO, 1'b0, NO, 1'b0, 1'b0, 1'b0, c1, c2, 1'b0);
    endfunction

    task automatic add(input logic [10:0] p, input logic [15:0] j, input logic r, input logic c,
                       input logic [14:0] e);
        vec_t v;
        v.ps2 = p; v.joy = j; v.rot = r; v.clr = c; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge
    task automatic step(input logic [10:0] p, input logic [15:0] j, input logic r, input logic c,
                        input logic [14:0] e, input string name);
        sb_t s;
        ps2_key = p; joy = j; rotate = r; clear = c;
        cur_ps2 = p;
        s.exp = e; s.name = name;
        sbq.push_back(s);
        @(posedge clk_sys);
        #1;
        if (sbq.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            s = sbq.pop_front();
            check(s.name, got, s.exp);
        end
    endtask

    task automatic ev(input logic p, input logic [7:0] code, input logic [15:0] j,
                      input logic c, input logic [14:0] e, input string name);
        tog = ~tog;
        step(mk(tog, p, 1'b0, code), j, 1'b0, c, e, name);
    endtask

    task automatic hold(input logic [15:0] j, input logic c, input logic [14:0] e, input string name);
        step(cur_ps2, j, 1'b0, c, e, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        ps2_key = mk(1'b1, 1'b0, 1'b0, 8'h00);
        joy     = '0;
        rotate  = 1'b0;
        clear   = 1'b0;

        // Vector table
        add(mk(1,0,0,8'h00), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0)); // init cycle
        add(mk(1,0,0,8'h00), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0));
        add(mk(0,1,0,8'h75), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0)); // up press
        add(mk(0,1,0,8'h75), 16'h0000, 0, 0, o(UP,0,NO,0,0,0,0,0,0));
        add(mk(1,0,0,8'h75), 16'h0000, 0, 0, o(UP,0,NO,0,0,0,0,0,0)); // up release
        add(mk(1,0,0,8'h75), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0));
        add(mk(0,1,1,8'h75), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0)); // extended up
        add(mk(0,1,1,8'h75), 16'h0000, 0, 0, o(UP,0,NO,0,0,0,0,0,0));
        add(mk(1,0,1,8'h75), 16'h0000, 0, 0, o(UP,0,NO,0,0,0,0,0,0));
        add(mk(1,0,1,8'h75), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0));
        add(mk(1,0,1,8'h75), 16'h0002, 1, 0, o(UP,0,UP,0,0,0,0,0,0)); // rotated left
        add(mk(1,0,1,8'h75), 16'h0002, 0, 0, o(LT,0,LT,0,0,0,0,0,0));
        add(mk(1,0,1,8'h75), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0));
        add(mk(0,1,0,8'h29), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0)); // space press
        add(mk(1,1,0,8'h14), 16'h0000, 0, 0, o(NO,1,NO,0,0,0,0,0,0)); // ctrl press
        add(mk(0,0,0,8'h14), 16'h0000, 0, 0, o(NO,1,NO,0,0,0,0,0,0)); // ctrl release
        add(mk(0,0,0,8'h14), 16'h0000, 0, 0, o(NO,1,NO,0,0,0,0,0,0));
        add(mk(1,0,0,8'h29), 16'h0000, 0, 0, o(NO,1,NO,0,0,0,0,0,0)); // space release
        add(mk(1,0,0,8'h29), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0));
        add(mk(0,1,0,8'h1A), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0)); // unlisted code
        add(mk(0,1,0,8'h1A), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0));
        add(mk(1,1,1,8'h29), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0)); // extended space ignored
        add(mk(1,1,1,8'h29), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0));
        add(mk(0,1,0,8'h2D), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0)); // up2 press
        add(mk(0,1,0,8'h2D), 16'h0000, 1, 0, o(NO,0,RT,0,0,0,0,0,0)); // up2 rotated
        add(mk(1,0,0,8'h2D), 16'h0000, 0, 0, o(NO,0,UP,0,0,0,0,0,0));
        add(mk(1,0,0,8'h2D), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0));
        add(mk(0,1,0,8'h2C), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0)); // test press
        add(mk(0,1,0,8'h2C), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,1));
        add(mk(1,0,0,8'h2C), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,1));
        add(mk(1,0,0,8'h2C), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0));
        add(mk(0,1,0,8'h34), 16'h0001, 0, 0, o(RT,0,RT,0,0,0,0,0,0)); // event + joy together
        add(mk(0,1,0,8'h34), 16'h0000, 0, 0, o(NO,0,RT,0,0,0,0,0,0));
        add(mk(1,0,0,8'h34), 16'h0000, 0, 0, o(NO,0,RT,0,0,0,0,0,0));
        add(mk(1,0,0,8'h34), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0));
        add(mk(0,1,0,8'h23), 16'h0000, 0, 1, o(NO,0,NO,0,0,0,0,0,0)); // clear beats event
        add(mk(0,1,0,8'h23), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0));
        add(mk(0,1,0,8'h23), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0));
        add(mk(1,1,0,8'h05), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0)); // F1 press
        add(mk(1,1,0,8'h05), 16'h0000, 0, 0, o(NO,0,NO,0,1,0,1,0,0)); // start + coin
        add(mk(0,0,0,8'h05), 16'h0000, 0, 0, o(NO,0,NO,0,1,0,1,0,0));
        add(mk(0,0,0,8'h05), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,1,0,0));
        add(mk(0,0,0,8'h05), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,1,0,0));
        add(mk(0,0,0,8'h05), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0));
        add(mk(0,0,0,8'h05), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0));
        add(mk(0,0,0,8'h05), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0));
        add(mk(0,0,0,8'h05), 16'h0000, 0, 0, o(NO,0,NO,0,0,0,0,0,0));

        repeat (3) @(posedge clk_sys);
        #1;
        check("reset_outputs", got, '0);
        reset_n = 1'b1;

        foreach (vecs[i])
            step(vecs[i].ps2, vecs[i].joy, vecs[i].rot, vecs[i].clr, vecs[i].exp, $sformatf("vec%0d", i));
        tog = cur_ps2[10];

        // '5' held for 20 cycles: exactly one 4-cycle pulse
        ev(1'b1, 8'h2E, 16'h0, 1'b0, oc(0,0), "a_press5");
        for (int i = 0; i < 20; i++)
            hold(16'h0, 1'b0, oc(i < 4, 0), $sformatf("a_hold%0d", i));
        ev(1'b0, 8'h2E, 16'h0, 1'b0, oc(0,0), "a_rel5");
        for (int i = 0; i < 4; i++)
            hold(16'h0, 1'b0, oc(0,0), $sformatf("a_idle%0d", i));

        // Edge during gap dropped, edge after gap accepted
        ev(1'b1, 8'h2E, 16'h0, 1'b0, oc(0,0), "b0");
        hold(16'h0, 1'b0, oc(1,0), "b1");
        ev(1'b0, 8'h2E, 16'h0, 1'b0, oc(1,0), "b2");
        hold(16'h0, 1'b0, oc(1,0), "b3");
        hold(16'h0, 1'b0, oc(1,0), "b4");
        hold(16'h0, 1'b0, oc(0,0), "b5");
        ev(1'b1, 8'h2E, 16'h0, 1'b0, oc(0,0), "b6");
        ev(1'b0, 8'h2E, 16'h0, 1'b0, oc(0,0), "b7_gap_drop");
        hold(16'h0, 1'b0, oc(0,0), "b8");
        hold(16'h0, 1'b0, oc(0,0), "b9");
        ev(1'b1, 8'h2E, 16'h0, 1'b0, oc(0,0), "b10");
        hold(16'h0, 1'b0, oc(1,0), "b11_accept");
        ev(1'b0, 8'h2E, 16'h0, 1'b0, oc(1,0), "b12");
        hold(16'h0, 1'b0, oc(1,0), "b13");
        hold(16'h0, 1'b0, oc(1,0), "b14");
        for (int i = 0; i < 4; i++)
            hold(16'h0, 1'b0, oc(0,0), $sformatf("b_tail%0d", i));

        // Coin 2 via '6'
        ev(1'b1, 8'h36, 16'h0, 1'b0, oc(0,0), "c2_press");
        for (int i = 0; i < 6; i++)
            hold(16'h0, 1'b0, oc(0, i < 4), $sformatf("c2_hold%0d", i));
        ev(1'b0, 8'h36, 16'h0, 1'b0, oc(0,0), "c2_rel");
        for (int i = 0; i < 3; i++)
            hold(16'h0, 1'b0, oc(0,0), $sformatf("c2_idle%0d", i));

        // Joystick start1 inserts a coin; start2 during pulse adds none
        hold(16'h0020, 1'b0, o(NO,0,NO,0,1,0,1,0,0), "j_start1");
        for (int i = 0; i < 9; i++)
            hold(16'h0060, 1'b0, o(NO,0,NO,0,1,1,(i < 3),0,0), $sformatf("j_start2_%0d", i));
        hold(16'h0000, 1'b0, oc(0,0), "j_release");

        // Fire held by space after ctrl release; clear with start held
        ev(1'b1, 8'h29, 16'h0, 1'b0, oc(0,0), "d_space");
        ev(1'b1, 8'h14, 16'h0, 1'b0, o(NO,1,NO,0,0,0,0,0,0), "d_ctrl");
        ev(1'b0, 8'h14, 16'h0, 1'b0, o(NO,1,NO,0,0,0,0,0,0), "d_ctrl_rel");
        hold(16'h0, 1'b0, o(NO,1,NO,0,0,0,0,0,0), "d_fire_kept");
        hold(16'h0020, 1'b0, o(NO,1,NO,0,1,0,1,0,0), "d_start");
        hold(16'h0020, 1'b0, o(NO,1,NO,0,1,0,1,0,0), "d_pulse");
        hold(16'h0020, 1'b1, oc(0,0), "d_clear");
        for (int i = 0; i < 6; i++)
            hold(16'h0020, 1'b0, o(NO,0,NO,0,1,0,0,0,0), $sformatf("d_after%0d", i));
        hold(16'h0000, 1'b0, oc(0,0), "d_release");

        // Reset mid-pulse drops coin immediately, nothing resumes
        hold(16'h0020, 1'b0, o(NO,0,NO,0,1,0,1,0,0), "r_pulse");
        reset_n = 1'b0;
        joy     = '0;
        #1;
        check("r_async", got, '0);
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++)
            hold(16'h0, 1'b0, oc(0,0), $sformatf("r_after%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
